fal6567_sram_port_ctrl: RTL and testbench
=========================================

# fal6567_sram_port_ctrl

Services the scan converter's SRAM request streams against the single external asynchronous SRAM on the FAL6567 board. It time-multiplexes the scan-converter read stream, the buffered scan-converter write stream and an optional host port onto one SRAM bus. It uses a fixed 4-slot round-robin on clk33. It returns read data with a one-cycle latch strobe that the scan converter uses to load its colour register.

## Interface
Parameters:
- AW, 19, SRAM address width
- DW, 8, SRAM data width

Ports:
- clk33  in  1  system clock, 33 MHz; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- sc_wadr  in  AW  scan-converter write address; passed through unchanged, bit 18 included
- sc_wdat  in  DW  scan-converter write data
- sc_wr  in  1  one-cycle write strobe, qualifies sc_wadr/sc_wdat
- sc_radr  in  AW  scan-converter read address; sampled every read slot
- sc_rdat  out  DW  read data returned to the scan converter
- sc_rlatch  out  1  one-cycle strobe: sc_rdat is newly valid
- wr_ovr  out  1  sticky flag: a buffered write was overwritten before it was serviced
- sram_a  out  AW  SRAM address
- sram_d_o  out  DW  SRAM write data
- sram_d_i  in  DW  SRAM read data
- sram_d_oe  out  1  pad output enable for the data bus
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low
- host_cyc, host_we  in  1  host request and direction (FAL6567_SRAM_HOST_EN only)
- host_adr  in  AW  host address (FAL6567_SRAM_HOST_EN only)
- host_dato  in  DW  host write data (FAL6567_SRAM_HOST_EN only)
- host_dati  out  DW  host read data (FAL6567_SRAM_HOST_EN only)
- host_ack  out  1  host completion pulse (FAL6567_SRAM_HOST_EN only)

## Operation
- 2-bit slot counter `slot` is free-running. It resets to 0 and increments every clk33, wrapping 3→0.
- Slot 0 (RDA) and slot 2 (RDB): read at sc_radr. This gives one read per 2 clk33, matching the pixel-doubled output rate.
- Slot 1 (WR): write from the write buffer if `pending`; otherwise idle.
- Slot 3 (HOST): host access if enabled and host_cyc is set; otherwise idle.
- Idle slot: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_d_oe=0. sram_a holds its last value.
- Write buffer, one entry:
  - sc_wr captures sc_wadr/sc_wdat and sets `pending`.
  - A write slot that consumes the buffer clears `pending`.
  - sc_wr together with the consuming edge: the new data is captured and `pending` stays 1.
  - sc_wr while `pending`=1 and not being consumed: the buffer is overwritten and wr_ovr is set.
  - wr_ovr is cleared only by reset.
- Address and data bus: sram_a is driven unmodified from the selected source. The block adds no offset and no masking.
- All SRAM outputs are registered.

## Timing
- Reset values: sram_a=0, sram_d_o=0, sram_d_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sc_rdat=0, sc_rlatch=0, wr_ovr=0, host_dati=0, host_ack=0, slot=0, pending=0.
- Read: at edge E entering RDA/RDB, sram_a takes sc_radr, sram_ce_n=0 and sram_oe_n=0. At E+1, sram_d_i is captured into sc_rdat and sc_rlatch=1 for exactly one cycle. Latency from sc_radr sample to sc_rlatch is 1 cycle; sc_rlatch rises every 2 cycles.
- Write: at edge entering WR with `pending`, the block drives sram_a and sram_d_o, sets sram_d_oe=1, sram_ce_n=0, sram_we_n=0 for that one cycle. All return inactive at the next edge.
  - The board SRAM has tAS=0 and a write pulse of 10 ns or less; a single 30 ns cycle meets it.
- The buffer content used by a write slot is the value registered before the edge entering WR. A strobe on that same edge waits for the next WR slot, at most 4 cycles.
- Host (FAL6567_SRAM_HOST_EN only):
  - host_cyc must be held until host_ack.
  - Access occurs in the first HOST slot where host_cyc=1. host_ack pulses 1 cycle on the following edge. For reads, host_dati is valid with host_ack.
  - If host_cyc drops before its HOST slot, no access is made and no ack is given.
- Reset asserted mid-operation: all outputs go immediately to their reset values, any pending write is discarded, and the slot counter returns to 0.

## Configuration
- FAL6567_SRAM_HOST_EN defined: host ports exist and slot 3 serves the host.
- FAL6567_SRAM_HOST_EN not defined: host ports are absent and slot 3 is always idle. The slot schedule and all scan-converter timing are identical in both builds.

## Structure
- Package fal6567_sram_pkg holds:
  - the AW and DW constants
  - slot enum SLOT_RDA=2'd0, SLOT_WR=2'd1, SLOT_RDB=2'd2, SLOT_HOST=2'd3
- Sub-module fal6567_sram_wrbuf holds the write buffer: the one-entry buffer, `pending` and overrun logic, with a consume input and a sticky wr_ovr output.

## Test plan
- Reset, then hold sc_radr=19'h40010 with the SRAM model at that address = 8'h0A → sram_oe_n low in slots 0 and 2; sc_rlatch pulses every 2 cycles; sc_rdat=8'h0A.
- sc_wr pulse with sc_wadr=19'h40123, sc_wdat=8'h05 → exactly one sram_we_n low cycle, in the next WR slot, with sram_a=19'h40123, sram_d_o=8'h05, sram_d_oe=1; pending clears.
- Two sc_wr pulses 1 cycle apart before a WR slot, carrying data 8'h01 then 8'h02 → only 8'h02 is written; wr_ovr=1 and stays 1 until rst_n low.
- sc_wr on the edge entering WR → no write in that slot; the write occurs 4 cycles later.
- Host build: host_cyc=1, host_we=0, host_adr=19'h00100 with SRAM=8'h5A → access in slot 3; host_ack 1 cycle later with host_dati=8'h5A; scan-converter read cadence is unchanged.
- Assert rst_n low during a write slot → sram_we_n=1 and sram_d_oe=0 immediately; no write after release.

Source files
------------

// File: rtl/fal6567_sram_pkg.sv
// Shared constants and slot encoding for the FAL6567 SRAM port controller.
// No logic; types only.
// No flow control here; consumers own scheduling.
package fal6567_sram_pkg;

    localparam int AW = 19;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        SLOT_RDA  = 2'd0,
        SLOT_WR   = 2'd1,
        SLOT_RDB  = 2'd2,
        SLOT_HOST = 2'd3
    } slot_e;

endpackage

// File: rtl/fal6567_sram_wrbuf.sv
// One-entry write buffer between the scan converter write strobe and the WR slot.
// Latency: captured on the strobe edge, visible to the next consuming edge.
// No backpressure: a new strobe on an unserviced entry overwrites it and sets sticky wr_ovr.
module fal6567_sram_wrbuf #(
    parameter int AW = 19,
    parameter int DW = 8
) (
    input  logic          clk33,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdat,
    input  logic          consume,
    output logic          pending,
    output logic [AW-1:0] buf_adr,
    output logic [DW-1:0] buf_dat,
    output logic          wr_ovr
);

    // Capture on strobe; a strobe coincident with consumption re-arms the entry.
    always_ff @(posedge clk33 or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            buf_adr <= '0;
            buf_dat <= '0;
            wr_ovr  <= 1'b0;
        end else if (wr) begin
            buf_adr <= wadr;
            buf_dat <= wdat;
            pending <= 1'b1;
            if (pending && !consume) begin
                wr_ovr <= 1'b1;
            end
        end else if (consume) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/fal6567_sram_port_ctrl.sv
// Time-multiplexes scan-converter reads/writes (and host when FAL6567_SRAM_HOST_EN) onto one async SRAM.
// Latency: read data strobed on sc_rlatch one cycle after the read slot; writes wait at most 4 cycles.
// No backpressure: fixed 4-slot round-robin; host holds host_cyc until host_ack.
module fal6567_sram_port_ctrl
    import fal6567_sram_pkg::*;
#(
    parameter int AW = fal6567_sram_pkg::AW,
    parameter int DW = fal6567_sram_pkg::DW
) (
    input  logic          clk33,
    input  logic          rst_n,
    input  logic [AW-1:0] sc_wadr,
    input  logic [DW-1:0] sc_wdat,
    input  logic          sc_wr,
    input  logic [AW-1:0] sc_radr,
    output logic [DW-1:0] sc_rdat,
    output logic          sc_rlatch,
    output logic          wr_ovr,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d_o,
    input  logic [DW-1:0] sram_d_i,
    output logic          sram_d_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
`ifdef FAL6567_SRAM_HOST_EN
    input  logic          host_cyc,
    input  logic          host_we,
    input  logic [AW-1:0] host_adr,
    input  logic [DW-1:0] host_dato,
    output logic [DW-1:0] host_dati,
    output logic          host_ack,
`endif
    output logic          sram_we_n
);

    slot_e         slot;
    slot_e         slot_nxt;
    logic          pending;
    logic          consume;
    logic [AW-1:0] buf_adr;
    logic [DW-1:0] buf_dat;
    logic          rd_act;
    logic          rd_nxt;
    logic [AW-1:0] a_nxt;
    logic [DW-1:0] d_nxt;
    logic          d_oe_nxt;
    logic          ce_n_nxt;
    logic          oe_n_nxt;
    logic          we_n_nxt;
`ifdef FAL6567_SRAM_HOST_EN
    logic          host_act;
    logic          host_rd;
    logic          host_go;
    logic          host_rd_nxt;
`endif

    fal6567_sram_wrbuf #(.AW(AW), .DW(DW)) u_wrbuf (
        .clk33   (clk33),
        .rst_n   (rst_n),
        .wr      (sc_wr),
        .wadr    (sc_wadr),
        .wdat    (sc_wdat),
        .consume (consume),
        .pending (pending),
        .buf_adr (buf_adr),
        .buf_dat (buf_dat),
        .wr_ovr  (wr_ovr)
    );

    // Free-running slot counter.
    always_ff @(posedge clk33 or negedge rst_n) begin
        if (!rst_n) begin
            slot <= SLOT_RDA;
        end else begin
            slot <= slot_nxt;
        end
    end

    // Decode the slot being entered into the next registered bus state.
    always_comb begin
        slot_nxt = slot_e'(slot + 2'd1);
        a_nxt    = sram_a;
        d_nxt    = sram_d_o;
        d_oe_nxt = 1'b0;
        ce_n_nxt = 1'b1;
        oe_n_nxt = 1'b1;
        we_n_nxt = 1'b1;
        rd_nxt   = 1'b0;
        consume  = 1'b0;
`ifdef FAL6567_SRAM_HOST_EN
        host_go     = 1'b0;
        host_rd_nxt = 1'b0;
`endif
        case (slot_nxt)
            SLOT_RDA, SLOT_RDB: begin
                a_nxt    = sc_radr;
                ce_n_nxt = 1'b0;
                oe_n_nxt = 1'b0;
                rd_nxt   = 1'b1;
            end
            SLOT_WR: begin
                if (pending) begin
                    consume  = 1'b1;
                    a_nxt    = buf_adr;
                    d_nxt    = buf_dat;
                    d_oe_nxt = 1'b1;
                    ce_n_nxt = 1'b0;
                    we_n_nxt = 1'b0;
                end
            end
            SLOT_HOST: begin
`ifdef FAL6567_SRAM_HOST_EN
                if (host_cyc) begin
                    host_go  = 1'b1;
                    a_nxt    = host_adr;
                    ce_n_nxt = 1'b0;
                    if (host_we) begin
                        d_nxt    = host_dato;
                        d_oe_nxt = 1'b1;
                        we_n_nxt = 1'b0;
                    end else begin
                        oe_n_nxt    = 1'b0;
                        host_rd_nxt = 1'b1;
                    end
                end
`endif
            end
            default: ;
        endcase
    end

    // SRAM pins and scan-converter read return, all registered.
    always_ff @(posedge clk33 or negedge rst_n) begin
        if (!rst_n) begin
            sram_a    <= '0;
            sram_d_o  <= '0;
            sram_d_oe <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            rd_act    <= 1'b0;
            sc_rlatch <= 1'b0;
            sc_rdat   <= '0;
        end else begin
            sram_a    <= a_nxt;
            sram_d_o  <= d_nxt;
            sram_d_oe <= d_oe_nxt;
            sram_ce_n <= ce_n_nxt;
            sram_oe_n <= oe_n_nxt;
            sram_we_n <= we_n_nxt;
            rd_act    <= rd_nxt;
            sc_rlatch <= rd_act;
            if (rd_act) begin
                sc_rdat <= sram_d_i;
            end
        end
    end

`ifdef FAL6567_SRAM_HOST_EN
    // Host completion: ack one cycle after the HOST slot, read data alongside.
    always_ff @(posedge clk33 or negedge rst_n) begin
        if (!rst_n) begin
            host_act  <= 1'b0;
            host_rd   <= 1'b0;
            host_ack  <= 1'b0;
            host_dati <= '0;
        end else begin
            host_act <= host_go;
            host_rd  <= host_rd_nxt;
            host_ack <= host_act;
            if (host_act && host_rd) begin
                host_dati <= sram_d_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fal6567_sram_port_ctrl.sv
// Scoreboard bench for fal6567_sram_port_ctrl with a behavioural async SRAM.
// Bench-side slot tracker gives expected timing; queues hold expected reads/writes.
// Host scenario compiles only with FAL6567_SRAM_HOST_EN.
module tb_fal6567_sram_port_ctrl;

    localparam int TAW = 19;
    localparam int TDW = 8;

    typedef struct {
        logic [TAW-1:0] adr;
        logic [TDW-1:0] dat;
    } wr_t;

    logic           clk33 = 1'b0;
    logic           rst_n = 1'b0;
    logic [TAW-1:0] sc_wadr = '0;
    logic [TDW-1:0] sc_wdat = '0;
    logic           sc_wr = 1'b0;
    logic [TAW-1:0] sc_radr = '0;
    logic [TDW-1:0] sc_rdat;
    logic           sc_rlatch;
    logic           wr_ovr;
    logic [TAW-1:0] sram_a;
    logic [TDW-1:0] sram_d_o;
    logic [TDW-1:0] sram_d_i;
    logic           sram_d_oe;
    logic           sram_ce_n;
    logic           sram_oe_n;
    logic           sram_we_n;
`ifdef FAL6567_SRAM_HOST_EN
    logic           host_cyc = 1'b0;
    logic           host_we = 1'b0;
    logic [TAW-1:0] host_adr = '0;
    logic [TDW-1:0] host_dato = '0;
    logic [TDW-1:0] host_dati;
    logic           host_ack;
`endif

    logic [TDW-1:0] mem [0:(1<<TAW)-1];
    wr_t            exp_wr_q[$];
    logic [TDW-1:0] rd_q[$];
    int             n_checks = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             tb_slot = 0;
    int             last_wr_cyc = -1;

    fal6567_sram_port_ctrl dut (
        .clk33     (clk33),
        .rst_n     (rst_n),
        .sc_wadr   (sc_wadr),
        .sc_wdat   (sc_wdat),
        .sc_wr     (sc_wr),
        .sc_radr   (sc_radr),
        .sc_rdat   (sc_rdat),
        .sc_rlatch (sc_rlatch),
        .wr_ovr    (wr_ovr),
        .sram_a    (sram_a),
        .sram_d_o  (sram_d_o),
        .sram_d_i  (sram_d_i),
        .sram_d_oe (sram_d_oe),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
`ifdef FAL6567_SRAM_HOST_EN
        .host_cyc  (host_cyc),
        .host_we   (host_we),
        .host_adr  (host_adr),
        .host_dato (host_dato),
        .host_dati (host_dati),
        .host_ack  (host_ack),
`endif
        .sram_we_n (sram_we_n)
    );

    always #15 clk33 = ~clk33;

    assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'hEE;

    always @(posedge clk33) cyc <= cyc + 1;

    // Expected slot: 0 out of reset, +1 per edge.
    always @(posedge clk33 or negedge rst_n) begin
        if (!rst_n) tb_slot <= 0;
        else        tb_slot <= (tb_slot + 1) % 4;
    end

    // SRAM write side: every write cycle must match the head of the expected queue.
    always @(negedge clk33) begin
        wr_t e;
        if (rst_n && !sram_we_n) begin
            mem[sram_a] = sram_d_o;
            last_wr_cyc = cyc;
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got a=%h d=%h slot=%0d, required no write", sram_a, sram_d_o, tb_slot);
            end else begin
                e = exp_wr_q.pop_front();
                if (sram_a !== e.adr || sram_d_o !== e.dat || sram_d_oe !== 1'b1 ||
                    sram_ce_n !== 1'b0 || sram_oe_n !== 1'b1 || tb_slot != 1) begin
                    n_fail++;
                    $display("FAIL write_cycle: got a=%h d=%h oe=%b ce_n=%b oe_n=%b slot=%0d, required a=%h d=%h oe=1 ce_n=0 oe_n=1 slot=1",
                             sram_a, sram_d_o, sram_d_oe, sram_ce_n, sram_oe_n, tb_slot, e.adr, e.dat);
                end
            end
        end
    end

    initial begin
        #(30 * 20000);
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk33);
            if (tb_slot == s) return;
        end
    endtask

    task automatic wait_wr_drain(input string name);
        for (int i = 0; i < 12 && exp_wr_q.size() != 0; i++) @(negedge clk33);
        n_checks++;
        if (exp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d writes outstanding, required 0", name, exp_wr_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk33);
        rst_n = 1'b0;
        sc_wr = 1'b0;
        repeat (2) @(negedge clk33);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk33);
        n_checks++;
        if ({sram_a, sram_d_o, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n, sc_rdat, sc_rlatch, wr_ovr} !==
            {19'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got a=%h d=%h oe=%b ce_n=%b oe_n=%b we_n=%b rdat=%h rl=%b ovr=%b, required 0/0/0/1/1/1/0/0/0",
                     sram_a, sram_d_o, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n, sc_rdat, sc_rlatch, wr_ovr);
        end
`ifdef FAL6567_SRAM_HOST_EN
        n_checks++;
        if ({host_ack, host_dati} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_host: got ack=%b dati=%h, required 0/00", host_ack, host_dati);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk33);
        n_checks++;
        if (sram_ce_n !== 1'b1 || sc_rlatch !== 1'b0) begin
            n_fail++;
            $display("FAIL first_slot_idle: got ce_n=%b rl=%b, required 1/0", sram_ce_n, sc_rlatch);
        end
    endtask

    task automatic test_read();
        logic [TAW-1:0] radr;
        logic [TDW-1:0] e;
        logic           exp_l;
        logic           exp_oe_n;
        rd_q.delete();
        radr = 19'h40010;
        sc_radr = radr;
        wait_slot(3);
        rd_q.push_back(mem[radr]);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk33);
            exp_oe_n = !(tb_slot == 0 || tb_slot == 2);
            exp_l    = (tb_slot == 1 || tb_slot == 3);
            n_checks++;
            if (sram_oe_n !== exp_oe_n || sc_rlatch !== exp_l) begin
                n_fail++;
                $display("FAIL read_cadence: slot=%0d got oe_n=%b rl=%b, required oe_n=%b rl=%b",
                         tb_slot, sram_oe_n, sc_rlatch, exp_oe_n, exp_l);
            end
            if (!exp_oe_n) begin
                n_checks++;
                if (sram_a !== radr || sram_ce_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_addr: got a=%h ce_n=%b, required a=%h ce_n=0", sram_a, sram_ce_n, radr);
                end
            end
            if (exp_l) begin
                e = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
                n_checks++;
                if (sc_rdat !== e) begin
                    n_fail++;
                    $display("FAIL read_data: got %h, required %h (adr pattern %0d)", sc_rdat, e, i);
                end
                if (i >= 8) begin
                    radr = TAW'($urandom_range(0, (1 << TAW) - 1));
                    sc_radr = radr;
                end
                rd_q.push_back(mem[radr]);
            end
        end
    endtask

    task automatic test_write_single();
        wr_t w;
        wait_slot(2);
        w.adr = 19'h40123; w.dat = 8'h05;
        exp_wr_q.push_back(w);
        sc_wadr = w.adr; sc_wdat = w.dat; sc_wr = 1'b1;
        @(negedge clk33);
        sc_wr = 1'b0;
        wait_wr_drain("single_write");
        repeat (8) @(negedge clk33);
        n_checks++;
        if (wr_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_ovr: got wr_ovr=%b, required 0", wr_ovr);
        end
    endtask

    task automatic test_overwrite();
        wr_t w;
        wait_slot(2);
        w.adr = 19'h40200; w.dat = 8'h02;
        exp_wr_q.push_back(w);
        sc_wadr = w.adr; sc_wdat = 8'h01; sc_wr = 1'b1;
        @(negedge clk33);
        sc_wdat = 8'h02;
        @(negedge clk33);
        sc_wr = 1'b0;
        wait_wr_drain("overwrite_write");
        n_checks++;
        if (wr_ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: got wr_ovr=%b, required 1", wr_ovr);
        end
        repeat (10) @(negedge clk33);
        n_checks++;
        if (wr_ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got wr_ovr=%b, required 1", wr_ovr);
        end
        pulse_reset();
        n_checks++;
        if (wr_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got wr_ovr=%b, required 0", wr_ovr);
        end
    endtask

    task automatic test_strobe_on_wr_edge();
        wr_t w;
        int  c0;
        wait_slot(0);
        w.adr = 19'h40300; w.dat = 8'h33;
        exp_wr_q.push_back(w);
        sc_wadr = w.adr; sc_wdat = w.dat; sc_wr = 1'b1;
        c0 = cyc;
        @(negedge clk33);
        sc_wr = 1'b0;
        wait_wr_drain("wr_edge_write");
        n_checks++;
        if (last_wr_cyc - (c0 + 1) != 4) begin
            n_fail++;
            $display("FAIL wr_edge_delay: got %0d cycles, required 4", last_wr_cyc - (c0 + 1));
        end
    endtask

    task automatic test_back_to_back();
        wr_t a;
        wr_t b;
        wait_slot(2);
        a.adr = 19'h40310; a.dat = 8'hA1;
        b.adr = 19'h40311; b.dat = 8'hB2;
        exp_wr_q.push_back(a);
        sc_wadr = a.adr; sc_wdat = a.dat; sc_wr = 1'b1;
        @(negedge clk33);
        sc_wr = 1'b0;
        @(negedge clk33);
        exp_wr_q.push_back(b);
        sc_wadr = b.adr; sc_wdat = b.dat; sc_wr = 1'b1;
        @(negedge clk33);
        sc_wr = 1'b0;
        wait_wr_drain("back_to_back");
        n_checks++;
        if (wr_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_ovr: got wr_ovr=%b, required 0", wr_ovr);
        end
    endtask

    task automatic test_reset_mid_write();
        wr_t a;
        wait_slot(2);
        a.adr = 19'h40400; a.dat = 8'h44;
        exp_wr_q.push_back(a);
        sc_wadr = a.adr; sc_wdat = a.dat; sc_wr = 1'b1;
        @(negedge clk33);
        sc_wr = 1'b0;
        @(negedge clk33);
        sc_wadr = 19'h40500; sc_wdat = 8'h55; sc_wr = 1'b1;
        @(negedge clk33);
        sc_wr = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sram_we_n !== 1'b1 || sram_d_oe !== 1'b0 || sram_ce_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_write: got we_n=%b d_oe=%b ce_n=%b, required 1/0/1", sram_we_n, sram_d_oe, sram_ce_n);
        end
        @(negedge clk33);
        rst_n = 1'b1;
        repeat (12) @(negedge clk33);
        n_checks++;
        if (exp_wr_q.size() != 0 || mem[19'h40500] !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_discard: got q=%0d mem=%h, required q=0 mem=c3", exp_wr_q.size(), mem[19'h40500]);
        end
    endtask

`ifdef FAL6567_SRAM_HOST_EN
    task automatic test_host();
        logic [TDW-1:0] e;
        rd_q.delete();
        wait_slot(1);
        host_adr = 19'h00100; host_we = 1'b0; host_cyc = 1'b1;
        rd_q.push_back(mem[19'h00100]);
        @(negedge clk33);
        @(negedge clk33);
        n_checks++;
        if (sram_a !== 19'h00100 || sram_oe_n !== 1'b0 || sram_ce_n !== 1'b0 || sc_rlatch !== 1'b1) begin
            n_fail++;
            $display("FAIL host_slot: got a=%h oe_n=%b ce_n=%b rl=%b, required 00100/0/0/1", sram_a, sram_oe_n, sram_ce_n, sc_rlatch);
        end
        @(negedge clk33);
        e = rd_q.pop_front();
        n_checks++;
        if (host_ack !== 1'b1 || host_dati !== e || sc_rlatch !== 1'b0 || sram_oe_n !== 1'b0) begin
            n_fail++;
            $display("FAIL host_ack: got ack=%b dati=%h rl=%b oe_n=%b, required 1/%h/0/0", host_ack, host_dati, sc_rlatch, sram_oe_n, e);
        end
        host_cyc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk33);
            n_checks++;
            if (host_ack !== 1'b0 || sc_rlatch !== (tb_slot == 1 || tb_slot == 3)) begin
                n_fail++;
                $display("FAIL host_after: slot=%0d got ack=%b rl=%b, required ack=0", tb_slot, host_ack, sc_rlatch);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << TAW); i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        mem[19'h40010] = 8'h0A;
        mem[19'h00100] = 8'h5A;
        mem[19'h40500] = 8'hC3;
        test_reset();
        test_read();
        test_write_single();
        test_overwrite();
        test_strobe_on_wr_edge();
        test_back_to_back();
        test_reset_mid_write();
`ifdef FAL6567_SRAM_HOST_EN
        test_host();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
